// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline types for the hazard tracker: slot record, FSM states, index width.
// Latency: none (types and constants only).
// Backpressure: none.
package hazard_tracker_pkg;

    // Default register-index width for the tracker.
    localparam int REGW_DEFAULT = 5;
    // Widest register index a slot can carry; REGW must not exceed this.
    localparam int REGW_MAX = 8;

    // One pipeline slot: destination and the write/load attributes of its instruction.
    typedef struct packed {
        logic                valid;
        logic [REGW_MAX-1:0] rd;
        logic                regwrite;
        logic                memread;
    } slot_t;

    // RUN: normal flow. FREEZE: a load in MEM is waiting on data memory.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FREEZE = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_slot.sv
// Single pipeline slot register that can hold its value or load an invalid bubble.
// Latency: one clk edge from d to q.
// Backpressure: hold freezes the slot; hold dominates bubble.
module hazard_slot
    import hazard_tracker_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    // Slot register: clear on reset, keep on hold, otherwise take a bubble or the new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? slot_t'('0) : d;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks EX/MEM/WB destinations and drives stall/flush for load-use, taken branches and memory waits.
// Latency: control outputs are combinational; slot updates land on the next clk edge.
// Backpressure: dmem_busy on a MEM load freezes all slots; branches seen while frozen are replayed on unfreeze.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REGW = REGW_DEFAULT,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_branch_taken,
    input  logic            dmem_busy,
    output logic [REGW-1:0] rd_mem,
    output logic [REGW-1:0] rd_wb,
    output logic            regwrite_mem,
    output logic            regwrite_wb,
    output logic            memread_ex,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            stall_all,
    output logic [CNTW-1:0] stall_count
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    slot_t               ex_q, mem_q, wb_q;
    slot_t               id_entry;
    logic [REGW_MAX-1:0] rs1_ext, rs2_ext;
    state_t              state;
    logic                branch_pend;
    logic                branch_eff;
    logic                load_use;
    logic                lu_stall;
    logic                unused_wb_memread;

    assign unused_wb_memread = wb_q.memread;

    // Widen ID fields to slot width so all comparisons are made on full slot indices.
    always_comb begin
        id_entry                = '0;
        id_entry.valid          = id_valid;
        id_entry.rd[REGW-1:0]   = id_rd;
        id_entry.regwrite       = id_regwrite;
        id_entry.memread        = id_memread;
        rs1_ext                 = '0;
        rs1_ext[REGW-1:0]       = id_rs1;
        rs2_ext                 = '0;
        rs2_ext[REGW-1:0]       = id_rs2;
    end

    // Hazard detection and pipeline control; branch (live or deferred) outranks load-use.
    always_comb begin
        stall_all  = mem_q.valid && mem_q.memread && dmem_busy;
        load_use   = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                     ((id_use_rs1 && (rs1_ext == ex_q.rd)) ||
                      (id_use_rs2 && (rs2_ext == ex_q.rd)));
        branch_eff = !reset && !stall_all &&
                     (ex_branch_taken || ((state == ST_FREEZE) && branch_pend));
        lu_stall   = !reset && !stall_all && !branch_eff && load_use;
        pc_write    = !stall_all && !lu_stall;
        if_id_write = !stall_all && !lu_stall;
        if_id_flush = branch_eff;
        id_ex_flush = branch_eff || lu_stall;
    end

    hazard_slot u_ex (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_all),
        .bubble (branch_eff || load_use),
        .d      (id_entry),
        .q      (ex_q)
    );

    hazard_slot u_mem (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_all),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    hazard_slot u_wb (
        .clk    (clk),
        .reset  (reset),
        .hold   (stall_all),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // Tracker view of the slots; x0 destinations never report a write.
    always_comb begin
        rd_mem       = mem_q.rd[REGW-1:0];
        rd_wb        = wb_q.rd[REGW-1:0];
        regwrite_mem = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
        regwrite_wb  = wb_q.valid && wb_q.regwrite && (wb_q.rd != '0);
        memread_ex   = ex_q.valid && ex_q.memread;
    end

    // Freeze FSM; remembers a branch seen while frozen so it flushes on the first free cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            branch_pend <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stall_all) begin
                        state       <= ST_FREEZE;
                        branch_pend <= ex_branch_taken;
                    end
                end
                ST_FREEZE: begin
                    if (!dmem_busy) begin
                        state       <= ST_RUN;
                        branch_pend <= 1'b0;
                    end else begin
                        branch_pend <= branch_pend || ex_branch_taken;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    branch_pend <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of frozen and load-use bubble cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if ((stall_all || lu_stall) && !(&stall_count)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule
